// File: rtl/rx.sv
// ---------------------------------------------------------------------------
// rx -- serial receiver for the single-wire link driven by tx.
//
// Line format: idle high, one start bit (0), WIDTH data bits MSB first, then
// at least one bit time of high line (stop) before the next frame.  Each bit
// is sampled at its centre using a programmable clocks-per-bit count.
//
// Parameters
//   WIDTH         data bits per frame
//   CLKS_PER_BIT  clk cycles per bit on the line (>= 1)
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   rst           asynchronous, active-high reset
//   rx_si         serial input, idle high, may be asynchronous to clk
//   rx_po         last correctly framed word, held until the next good frame
//   rx_valid      one-cycle pulse, rx_po was just updated
//   rx_busy       high whenever the receiver FSM is outside IDLE
//   rx_frame_err  one-cycle pulse, stop bit sampled low and word discarded
// ---------------------------------------------------------------------------
module rx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_si,
    output logic [WIDTH-1:0] rx_po,
    output logic             rx_valid,
    output logic             rx_busy,
    output logic             rx_frame_err
);

    // Offset from the detected falling edge to the centre of the start bit.
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW   = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]       sync_q;
    logic             s_line;
    logic             stop_sample;
    logic             valid_d;
    logic             err_d;
    logic             busy_d;

    // ------------------------------------------------------------------
    // Input synchronizer.  Both flops reset high so a reset never looks
    // like a falling edge on the line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_si};
        end
    end

    assign s_line = sync_q[1];

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;

        unique case (state_q)
            S_IDLE: begin
                if (!s_line) begin
                    if (HALF > 0) begin
                        state_d = S_START;
                        cnt_d   = CNT_HALF;
                    end else begin
                        // With no half-bit offset the detecting sample
                        // already is the start-bit centre sample.
                        state_d = S_DATA;
                        cnt_d   = CNT_BIT;
                        idx_d   = '0;
                    end
                end
            end

            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!s_line) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_BIT;
                    idx_d   = '0;
                end else begin
                    // Line back high at the start-bit centre: a glitch.
                    state_d = S_IDLE;
                end
            end

            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shreg_d = {shreg_q[WIDTH-2:0], s_line};
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = CNT_BIT;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (s_line) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end

            S_BREAK: begin
                // Held-low line: wait for it to return high so a long
                // break produces exactly one error pulse.
                if (s_line) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode.  Pulses are derived from the stop-bit sample and
    // registered below; busy follows the next state so it lines up with
    // the cycles the FSM spends outside IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        stop_sample = (state_q == S_STOP) && (cnt_q == '0);
        valid_d     = stop_sample && s_line;
        err_d       = stop_sample && !s_line;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_po        <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_valid     <= valid_d;
            rx_frame_err <= err_d;
            rx_busy      <= busy_d;
            if (valid_d) begin
                rx_po <= shreg_q;
            end
        end
    end

endmodule
